// File: rtl/alu_issue_queue.sv
// ALU reservation station: holds dispatched uops until both operands are ready,
// snoops writeback broadcasts by ROB tag, and issues the oldest ready entry each cycle.
package decode_pkg;
   typedef struct packed {
      logic [3:0] opcode;
      logic       is_branch;
      logic       is_jump;
      logic [4:0] rd;
   } uop_t;
endpackage

module alu_issue_queue #(
   parameter int DEPTH    = 8,
   parameter int TAG_W    = 6,
   parameter int XLEN     = 32,
   parameter int WB_PORTS = 2,
   parameter int CNT_W    = $clog2(DEPTH + 1)
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      flush_i,
   input  logic                      disp_valid_i,
   output logic                      disp_ready_o,
   input  decode_pkg::uop_t          disp_uop_i,
   input  logic [TAG_W-1:0]          disp_rob_tag_i,
   input  logic                      disp_rs1_rdy_i,
   input  logic                      disp_rs2_rdy_i,
   input  logic [TAG_W-1:0]          disp_rs1_tag_i,
   input  logic [TAG_W-1:0]          disp_rs2_tag_i,
   input  logic [XLEN-1:0]           disp_rs1_data_i,
   input  logic [XLEN-1:0]           disp_rs2_data_i,
   input  logic [WB_PORTS-1:0]       wb_valid_i,
   input  logic [WB_PORTS*TAG_W-1:0] wb_tag_i,
   input  logic [WB_PORTS*XLEN-1:0]  wb_data_i,
   input  logic                      alu_ready_i,
   output logic                      alu_valid_o,
   output decode_pkg::uop_t          alu_uop_o,
   output logic [XLEN-1:0]           alu_rs1_data_o,
   output logic [XLEN-1:0]           alu_rs2_data_o,
   output logic [TAG_W-1:0]          alu_rob_tag_o,
   output logic [CNT_W-1:0]          count_o
);

   logic [DEPTH-1:0]   valid, rs1_rdy, rs2_rdy;
   decode_pkg::uop_t   uop      [DEPTH];
   logic [TAG_W-1:0]   rob_tag  [DEPTH];
   logic [TAG_W-1:0]   rs1_tag  [DEPTH];
   logic [TAG_W-1:0]   rs2_tag  [DEPTH];
   logic [XLEN-1:0]    rs1_data [DEPTH];
   logic [XLEN-1:0]    rs2_data [DEPTH];
   logic [DEPTH-1:0]   age      [DEPTH];
   logic [CNT_W-1:0]   count;

   logic [DEPTH-1:0]   eligible, grant, issue_oh, alloc_oh, alloc_mask;
   logic               disp_fire, issue_fire, slot_found;
   logic [XLEN:0]      wake1 [DEPTH];
   logic [XLEN:0]      wake2 [DEPTH];
   logic [XLEN:0]      disp_wake1, disp_wake2;

   // Returns {hit, data}; ports are scanned high to low so the lowest index wins.
   function automatic logic [XLEN:0] snoop(input logic [TAG_W-1:0] tag);
      logic [XLEN:0] r;
      r = '0;
      for (int p = WB_PORTS - 1; p >= 0; p--) begin
         if (wb_valid_i[p] && wb_tag_i[p*TAG_W +: TAG_W] == tag)
            r = {1'b1, wb_data_i[p*XLEN +: XLEN]};
      end
      return r;
   endfunction

   always_comb begin
      eligible   = valid & rs1_rdy & rs2_rdy;
      grant      = '0;
      alloc_oh   = '0;
      slot_found = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         grant[i] = eligible[i] && ((age[i] & eligible) == '0);
         wake1[i] = snoop(rs1_tag[i]);
         wake2[i] = snoop(rs2_tag[i]);
         if (!valid[i] && !slot_found) begin
            alloc_oh[i] = 1'b1;
            slot_found  = 1'b1;
         end
      end
      disp_wake1   = snoop(disp_rs1_tag_i);
      disp_wake2   = snoop(disp_rs2_tag_i);
      disp_ready_o = (count != CNT_W'(DEPTH));
      alu_valid_o  = (|eligible) && !flush_i;
      issue_fire   = alu_valid_o && alu_ready_i;
      disp_fire    = disp_valid_i && disp_ready_o && !flush_i;
      issue_oh     = issue_fire ? grant : '0;
      alloc_mask   = disp_fire ? alloc_oh : '0;
   end

   always_comb begin
      alu_uop_o      = '0;
      alu_rs1_data_o = '0;
      alu_rs2_data_o = '0;
      alu_rob_tag_o  = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (alu_valid_o && grant[i]) begin
            alu_uop_o      = uop[i];
            alu_rs1_data_o = rs1_data[i];
            alu_rs2_data_o = rs2_data[i];
            alu_rob_tag_o  = rob_tag[i];
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i || flush_i) begin
         valid <= '0;
         count <= '0;
         for (int i = 0; i < DEPTH; i++) age[i] <= '0;
      end else begin
         count <= count + CNT_W'(disp_fire) - CNT_W'(issue_fire);
         for (int i = 0; i < DEPTH; i++) begin
            if (valid[i] && !rs1_rdy[i] && wake1[i][XLEN]) begin
               rs1_rdy[i]  <= 1'b1;
               rs1_data[i] <= wake1[i][XLEN-1:0];
            end
            if (valid[i] && !rs2_rdy[i] && wake2[i][XLEN]) begin
               rs2_rdy[i]  <= 1'b1;
               rs2_data[i] <= wake2[i][XLEN-1:0];
            end
            if (issue_oh[i]) valid[i] <= 1'b0;
            // A new entry is younger than every survivor, but not the one leaving now.
            if (alloc_mask[i]) begin
               valid[i]    <= 1'b1;
               uop[i]      <= disp_uop_i;
               rob_tag[i]  <= disp_rob_tag_i;
               rs1_tag[i]  <= disp_rs1_tag_i;
               rs2_tag[i]  <= disp_rs2_tag_i;
               rs1_rdy[i]  <= disp_rs1_rdy_i | disp_wake1[XLEN];
               rs2_rdy[i]  <= disp_rs2_rdy_i | disp_wake2[XLEN];
               rs1_data[i] <= disp_rs1_rdy_i ? disp_rs1_data_i : disp_wake1[XLEN-1:0];
               rs2_data[i] <= disp_rs2_rdy_i ? disp_rs2_data_i : disp_wake2[XLEN-1:0];
               age[i]      <= valid & ~issue_oh;
            end else begin
               age[i] <= age[i] & ~alloc_mask & ~issue_oh;
            end
         end
      end
   end

   assign count_o = count;

endmodule

// File: tb/tb_alu_issue_queue.sv
// Directed bench for alu_issue_queue: reset, issue, wakeup, snoop, age order,
// backpressure/full, back-to-back and flush scenarios with hand-computed expectations.
module tb_alu_issue_queue;

   logic             clk = 1'b0;
   logic             rst, flush;
   logic             disp_valid, disp_ready;
   decode_pkg::uop_t disp_uop, alu_uop, exp_uop;
   logic [5:0]       disp_rob_tag, disp_rs1_tag, disp_rs2_tag, alu_rob_tag;
   logic             disp_rs1_rdy, disp_rs2_rdy;
   logic [31:0]      disp_rs1_data, disp_rs2_data, alu_rs1_data, alu_rs2_data;
   logic [1:0]       wb_valid;
   logic [11:0]      wb_tag;
   logic [63:0]      wb_data;
   logic             alu_ready, alu_valid;
   logic [3:0]       count;
   int               n_checks = 0;
   int               n_fail   = 0;

   alu_issue_queue dut (
      .clk_i(clk), .rst_i(rst), .flush_i(flush),
      .disp_valid_i(disp_valid), .disp_ready_o(disp_ready), .disp_uop_i(disp_uop),
      .disp_rob_tag_i(disp_rob_tag), .disp_rs1_rdy_i(disp_rs1_rdy), .disp_rs2_rdy_i(disp_rs2_rdy),
      .disp_rs1_tag_i(disp_rs1_tag), .disp_rs2_tag_i(disp_rs2_tag),
      .disp_rs1_data_i(disp_rs1_data), .disp_rs2_data_i(disp_rs2_data),
      .wb_valid_i(wb_valid), .wb_tag_i(wb_tag), .wb_data_i(wb_data),
      .alu_ready_i(alu_ready), .alu_valid_o(alu_valid), .alu_uop_o(alu_uop),
      .alu_rs1_data_o(alu_rs1_data), .alu_rs2_data_o(alu_rs2_data),
      .alu_rob_tag_o(alu_rob_tag), .count_o(count)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      disp_valid = 1'b0;
      wb_valid   = '0;
      flush      = 1'b0;
   endtask

   task automatic drive_disp(input logic [5:0] tag, input logic r1_rdy, input logic [5:0] r1_tag,
                             input logic [31:0] r1_data, input logic r2_rdy, input logic [5:0] r2_tag,
                             input logic [31:0] r2_data);
      disp_valid       = 1'b1;
      disp_uop         = '0;
      disp_uop.opcode  = tag[3:0];
      disp_uop.rd      = tag[4:0];
      disp_rob_tag     = tag;
      disp_rs1_rdy     = r1_rdy;
      disp_rs1_tag     = r1_tag;
      disp_rs1_data    = r1_data;
      disp_rs2_rdy     = r2_rdy;
      disp_rs2_tag     = r2_tag;
      disp_rs2_data    = r2_data;
   endtask

   task automatic drive_wb(input int p, input logic [5:0] tag, input logic [31:0] data);
      wb_valid[p]          = 1'b1;
      wb_tag[p*6 +: 6]     = tag;
      wb_data[p*32 +: 32]  = data;
   endtask

   task automatic test_reset();
      rst = 1'b1; alu_ready = 1'b0; idle();
      drive_disp(6'd1, 1'b1, 6'd0, 32'd1, 1'b1, 6'd0, 32'd2);
      tick(); tick();
      rst = 1'b0; idle(); #1;
      n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", count); end
      n_checks++; if (disp_ready !== 1'b1) begin n_fail++; $display("FAIL reset_disp_ready got=%0b exp=1", disp_ready); end
      n_checks++; if ({alu_valid, alu_rs1_data, alu_rs2_data, alu_rob_tag} !== '0)
         begin n_fail++; $display("FAIL reset_outputs got valid=%0b tag=%0d exp all zero", alu_valid, alu_rob_tag); end
      // Reset while holding entries discards them.
      drive_disp(6'd2, 1'b1, 6'd0, 32'd1, 1'b1, 6'd0, 32'd2); tick();
      drive_disp(6'd3, 1'b1, 6'd0, 32'd1, 1'b1, 6'd0, 32'd2); tick();
      idle(); #1;
      n_checks++; if (count !== 4'd2) begin n_fail++; $display("FAIL pre_reset_count got=%0d exp=2", count); end
      rst = 1'b1; tick(); rst = 1'b0; alu_ready = 1'b1; #1;
      n_checks++; if (count !== 4'd0 || alu_valid !== 1'b0)
         begin n_fail++; $display("FAIL mid_reset got count=%0d valid=%0b exp 0/0", count, alu_valid); end
   endtask

   task automatic test_basic_issue();
      drive_disp(6'd3, 1'b1, 6'd0, 32'd5, 1'b1, 6'd0, 32'd7); #1;
      n_checks++; if (disp_ready !== 1'b1) begin n_fail++; $display("FAIL basic_disp_ready got=%0b exp=1", disp_ready); end
      tick(); idle(); #1;
      exp_uop = '0; exp_uop.opcode = 4'd3; exp_uop.rd = 5'd3;
      n_checks++; if (alu_valid !== 1'b1 || alu_rob_tag !== 6'd3)
         begin n_fail++; $display("FAIL basic_issue got valid=%0b tag=%0d exp 1/3", alu_valid, alu_rob_tag); end
      n_checks++; if (alu_rs1_data !== 32'd5 || alu_rs2_data !== 32'd7)
         begin n_fail++; $display("FAIL basic_operands got %0d/%0d exp 5/7", alu_rs1_data, alu_rs2_data); end
      n_checks++; if (alu_uop !== exp_uop) begin n_fail++; $display("FAIL basic_uop got=%h exp=%h", alu_uop, exp_uop); end
      tick(); #1;
      n_checks++; if (count !== 4'd0 || alu_valid !== 1'b0)
         begin n_fail++; $display("FAIL basic_drain got count=%0d valid=%0b exp 0/0", count, alu_valid); end
   endtask

   task automatic test_wakeup();
      drive_disp(6'd4, 1'b0, 6'd9, 32'd0, 1'b1, 6'd0, 32'd1);
      tick(); idle(); #1;
      n_checks++; if (alu_valid !== 1'b0 || count !== 4'd1)
         begin n_fail++; $display("FAIL wake_wait got valid=%0b count=%0d exp 0/1", alu_valid, count); end
      tick();
      drive_wb(1, 6'd9, 32'h1234); #1;
      n_checks++; if (alu_valid !== 1'b0) begin n_fail++; $display("FAIL wake_no_bypass got=%0b exp=0", alu_valid); end
      tick(); idle(); #1;
      n_checks++; if (alu_valid !== 1'b1 || alu_rob_tag !== 6'd4 || alu_rs1_data !== 32'h1234)
         begin n_fail++; $display("FAIL wake_issue got valid=%0b tag=%0d rs1=%h exp 1/4/1234", alu_valid, alu_rob_tag, alu_rs1_data); end
      tick(); #1;
      n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL wake_drain got=%0d exp=0", count); end
   endtask

   task automatic test_dispatch_snoop();
      // rs1 is already ready with a tag that also broadcasts: it must keep 0x11.
      drive_disp(6'd5, 1'b1, 6'd2, 32'h11, 1'b0, 6'd2, 32'd0);
      drive_wb(0, 6'd2, 32'hAA);
      drive_wb(1, 6'd2, 32'hBB);
      tick(); idle(); #1;
      n_checks++; if (alu_valid !== 1'b1 || alu_rob_tag !== 6'd5)
         begin n_fail++; $display("FAIL snoop_issue got valid=%0b tag=%0d exp 1/5", alu_valid, alu_rob_tag); end
      n_checks++; if (alu_rs2_data !== 32'hAA) begin n_fail++; $display("FAIL snoop_rs2 got=%h exp=aa", alu_rs2_data); end
      n_checks++; if (alu_rs1_data !== 32'h11) begin n_fail++; $display("FAIL snoop_rs1_kept got=%h exp=11", alu_rs1_data); end
      tick();
   endtask

   task automatic test_age_order();
      for (int k = 0; k < 3; k++) begin
         drive_disp(6'(10 + k), 1'b0, 6'd1, 32'd0, 1'b1, 6'd0, 32'd0);
         tick();
      end
      idle(); #1;
      n_checks++; if (alu_valid !== 1'b0 || count !== 4'd3)
         begin n_fail++; $display("FAIL age_wait got valid=%0b count=%0d exp 0/3", alu_valid, count); end
      drive_wb(0, 6'd1, 32'h77);
      tick(); idle();
      for (int k = 0; k < 3; k++) begin
         #1;
         n_checks++; if (alu_valid !== 1'b1 || alu_rob_tag !== 6'(10 + k) || alu_rs1_data !== 32'h77)
            begin n_fail++; $display("FAIL age_order got tag=%0d rs1=%h exp %0d/77", alu_rob_tag, alu_rs1_data, 10 + k); end
         tick();
      end
      #1;
      n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL age_drain got=%0d exp=0", count); end
   endtask

   task automatic test_full_backpressure();
      logic [5:0] exp_tag;
      alu_ready = 1'b0;
      for (int k = 0; k < 8; k++) begin
         drive_disp(6'(20 + k), 1'b1, 6'd0, 32'(k), 1'b1, 6'd0, 32'(k));
         tick();
      end
      idle(); #1;
      n_checks++; if (count !== 4'd8 || disp_ready !== 1'b0)
         begin n_fail++; $display("FAIL full_state got count=%0d ready=%0b exp 8/0", count, disp_ready); end
      n_checks++; if (alu_valid !== 1'b1 || alu_rob_tag !== 6'd20)
         begin n_fail++; $display("FAIL full_head got valid=%0b tag=%0d exp 1/20", alu_valid, alu_rob_tag); end
      tick(); #1;
      n_checks++; if (alu_rob_tag !== 6'd20) begin n_fail++; $display("FAIL full_stable got=%0d exp=20", alu_rob_tag); end
      // Full with a concurrent issue still refuses the dispatch.
      drive_disp(6'd62, 1'b1, 6'd0, 32'd0, 1'b1, 6'd0, 32'd0);
      alu_ready = 1'b1; #1;
      n_checks++; if (disp_ready !== 1'b0) begin n_fail++; $display("FAIL full_issue_ready got=%0b exp=0", disp_ready); end
      tick(); idle(); alu_ready = 1'b0; #1;
      n_checks++; if (count !== 4'd7 || disp_ready !== 1'b1)
         begin n_fail++; $display("FAIL one_issue got count=%0d ready=%0b exp 7/1", count, disp_ready); end
      n_checks++; if (alu_rob_tag !== 6'd21) begin n_fail++; $display("FAIL next_head got=%0d exp=21", alu_rob_tag); end
      drive_disp(6'd28, 1'b1, 6'd0, 32'd0, 1'b1, 6'd0, 32'd0);
      tick(); idle(); #1;
      n_checks++; if (count !== 4'd8) begin n_fail++; $display("FAIL refill_count got=%0d exp=8", count); end
      // Tag 28 reuses slot 0 but is the youngest, so it drains last.
      alu_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         exp_tag = (k < 7) ? 6'(21 + k) : 6'd28;
         #1;
         n_checks++; if (alu_valid !== 1'b1 || alu_rob_tag !== exp_tag)
            begin n_fail++; $display("FAIL drain_order got valid=%0b tag=%0d exp 1/%0d", alu_valid, alu_rob_tag, exp_tag); end
         tick();
      end
      #1;
      n_checks++; if (count !== 4'd0 || alu_valid !== 1'b0)
         begin n_fail++; $display("FAIL full_drain got count=%0d valid=%0b exp 0/0", count, alu_valid); end
   endtask

   task automatic test_back_to_back();
      alu_ready = 1'b1;
      drive_disp(6'd30, 1'b1, 6'd0, 32'd0, 1'b1, 6'd0, 32'd0);
      tick();
      drive_disp(6'd31, 1'b1, 6'd0, 32'd0, 1'b1, 6'd0, 32'd0); #1;
      n_checks++; if (alu_rob_tag !== 6'd30) begin n_fail++; $display("FAIL b2b_first got=%0d exp=30", alu_rob_tag); end
      tick(); #1;
      n_checks++; if (count !== 4'd1) begin n_fail++; $display("FAIL b2b_count got=%0d exp=1", count); end
      drive_disp(6'd32, 1'b1, 6'd0, 32'd0, 1'b1, 6'd0, 32'd0); #1;
      n_checks++; if (alu_rob_tag !== 6'd31) begin n_fail++; $display("FAIL b2b_second got=%0d exp=31", alu_rob_tag); end
      tick(); idle(); #1;
      n_checks++; if (count !== 4'd1 || alu_rob_tag !== 6'd32)
         begin n_fail++; $display("FAIL b2b_third got count=%0d tag=%0d exp 1/32", count, alu_rob_tag); end
      tick(); #1;
      n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL b2b_drain got=%0d exp=0", count); end
   endtask

   task automatic test_flush();
      alu_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         drive_disp(6'(40 + k), 1'b1, 6'd0, 32'd0, 1'b1, 6'd0, 32'd0);
         tick();
      end
      idle(); #1;
      n_checks++; if (count !== 4'd5) begin n_fail++; $display("FAIL flush_pre got=%0d exp=5", count); end
      drive_disp(6'd45, 1'b1, 6'd0, 32'd0, 1'b1, 6'd0, 32'd0);
      flush = 1'b1; alu_ready = 1'b1; #1;
      n_checks++; if (alu_valid !== 1'b0) begin n_fail++; $display("FAIL flush_suppress got=%0b exp=0", alu_valid); end
      tick(); idle(); #1;
      n_checks++; if (count !== 4'd0 || alu_valid !== 1'b0 || disp_ready !== 1'b1)
         begin n_fail++; $display("FAIL flush_post got count=%0d valid=%0b ready=%0b exp 0/0/1", count, alu_valid, disp_ready); end
      for (int k = 0; k < 3; k++) begin
         tick();
         n_checks++; if (alu_valid !== 1'b0) begin n_fail++; $display("FAIL flush_no_issue got tag=%0d exp none", alu_rob_tag); end
      end
   endtask

   initial begin
      wb_tag = '0; wb_data = '0; disp_uop = '0; disp_rob_tag = '0;
      disp_rs1_rdy = 1'b0; disp_rs2_rdy = 1'b0; disp_rs1_tag = '0; disp_rs2_tag = '0;
      disp_rs1_data = '0; disp_rs2_data = '0;
      test_reset();
      test_basic_issue();
      test_wakeup();
      test_dispatch_snoop();
      test_age_order();
      test_full_backpressure();
      test_back_to_back();
      test_flush();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
